// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//   Two-requester write-back arbiter in front of a register file. Each
//   requester owns a one-entry holding buffer; at most one buffered write is
//   issued per cycle, with a round-robin pointer resolving contention.
//   Writes aimed at register 0 are accepted and discarded, and a one-cycle
//   zero_drop pulse reports the discard.
//
// Ports
//   clock            sole clock, rising edge
//   reset            asynchronous, active-low
//   a_valid/a_reg/a_data/a_ready   requester A handshake (ready = buffer empty)
//   b_valid/b_reg/b_data/b_ready   requester B handshake
//   flush            synchronous discard of buffered and in-flight writes
//   wr_enable/wr_reg/wr_data       registered register-file write port
//   grant_b          1 = current write came from B, 0 = from A
//   zero_drop        one-cycle pulse when a register-0 request is discarded
// -----------------------------------------------------------------------------
module wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_valid,
    input  logic [REG_W-1:0]  a_reg,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [REG_W-1:0]  b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    input  logic              flush,
    output logic              wr_enable,
    output logic [REG_W-1:0]  wr_reg,
    output logic [DATA_W-1:0] wr_data,
    output logic              grant_b,
    output logic              zero_drop
);

    typedef enum logic {EMPTY, FULL} buf_state_t;
    typedef enum logic {PRI_A, PRI_B} pri_t;

    buf_state_t a_state, a_state_nxt;
    buf_state_t b_state, b_state_nxt;
    pri_t       pri, pri_nxt;

    logic [REG_W-1:0]  a_reg_p0, b_reg_p0;
    logic [DATA_W-1:0] a_data_p0, b_data_p0;

    logic accept_a, accept_b;
    logic gnt_a, gnt_b;
    logic zero_drop_nxt;
    logic wr_enable_nxt;

    // Ready comes straight from the buffer state flops, so there is no
    // combinational path from any input to a_ready/b_ready.
    assign a_ready = (a_state == EMPTY);
    assign b_ready = (b_state == EMPTY);

    always_comb begin
        accept_a      = 1'b0;
        accept_b      = 1'b0;
        gnt_a         = 1'b0;
        gnt_b         = 1'b0;
        a_state_nxt   = a_state;
        b_state_nxt   = b_state;
        pri_nxt       = pri;
        zero_drop_nxt = 1'b0;
        wr_enable_nxt = 1'b0;

        // An EMPTY buffer can never be granted, so accepting and granting
        // the same buffer on one edge cannot happen.
        accept_a = a_valid && (a_state == EMPTY);
        accept_b = b_valid && (b_state == EMPTY);

        gnt_a = (a_state == FULL) && ((b_state == EMPTY) || (pri == PRI_A));
        gnt_b = (b_state == FULL) && ((a_state == EMPTY) || (pri == PRI_B));

        if (flush) begin
            a_state_nxt = EMPTY;
            b_state_nxt = EMPTY;
            pri_nxt     = PRI_A;
        end else begin
            if (gnt_a)
                a_state_nxt = EMPTY;
            else if (accept_a && (a_reg != '0))
                a_state_nxt = FULL;

            if (gnt_b)
                b_state_nxt = EMPTY;
            else if (accept_b && (b_reg != '0))
                b_state_nxt = FULL;

            if (gnt_a)
                pri_nxt = PRI_B;
            else if (gnt_b)
                pri_nxt = PRI_A;

            zero_drop_nxt = (accept_a && (a_reg == '0)) ||
                            (accept_b && (b_reg == '0));
            wr_enable_nxt = gnt_a || gnt_b;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_state   <= EMPTY;
            b_state   <= EMPTY;
            pri       <= PRI_A;
            wr_enable <= 1'b0;
            wr_reg    <= '0;
            wr_data   <= '0;
            grant_b   <= 1'b0;
            zero_drop <= 1'b0;
        end else begin
            a_state   <= a_state_nxt;
            b_state   <= b_state_nxt;
            pri       <= pri_nxt;
            wr_enable <= wr_enable_nxt;
            zero_drop <= zero_drop_nxt;
            // Write fields only move on an actual issue; otherwise they hold.
            if (wr_enable_nxt) begin
                wr_reg  <= gnt_b ? b_reg_p0  : a_reg_p0;
                wr_data <= gnt_b ? b_data_p0 : a_data_p0;
                grant_b <= gnt_b;
            end
        end
    end

    // ---- p0: holding-buffer payload (qualified by a_state/b_state) ----
    always_ff @(posedge clock) begin
        if (accept_a) begin
            a_reg_p0  <= a_reg;
            a_data_p0 <= a_data;
        end
        if (accept_b) begin
            b_reg_p0  <= b_reg;
            b_data_p0 <= b_data;
        end
    end

endmodule
